sprite_draw_scheduler: RTL and testbench

Central arbiter that owns the single VGA pixel-write port and shares it among N sprite engines (cars, player, etc.). On each frame tick it walks the sprites in index order. For each enabled sprite it pulses that sprite's start enable, forwards that sprite's plot/x/y/colour stream to the VGA adapter, and waits for the sprite's finish pulse. It is the initiator/consumer end of the sprite start/finish and pixel-stream interface.

---
 rtl/sprite_draw_scheduler_if.sv | 42 ++++
 rtl/sprite_draw_scheduler.sv | 156 +++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_draw_scheduler_if.sv
// Sprite start/finish handshake, per-sprite pixel streams and the shared VGA write port.
// The scheduler uses the master side; sprite engines and the VGA adapter sit on the slave side.
interface sprite_draw_scheduler_if #(
  parameter int unsigned N_SPRITES = 4
);
  logic [N_SPRITES-1:0]   sprite_en;
  logic [N_SPRITES-1:0]   sprite_done;
  logic [N_SPRITES-1:0]   sprite_plot;
  logic [8*N_SPRITES-1:0] sprite_x;
  logic [7*N_SPRITES-1:0] sprite_y;
  logic [3*N_SPRITES-1:0] sprite_colour;
  logic                   vga_plot;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [2:0]             vga_colour;

  modport master (
    output sprite_en,
    input  sprite_done,
    input  sprite_plot,
    input  sprite_x,
    input  sprite_y,
    input  sprite_colour,
    output vga_plot,
    output vga_x,
    output vga_y,
    output vga_colour
  );

  modport slave (
    input  sprite_en,
    output sprite_done,
    output sprite_plot,
    output sprite_x,
    output sprite_y,
    output sprite_colour,
    input  vga_plot,
    input  vga_x,
    input  vga_y,
    input  vga_colour
  );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// Walks enabled sprites in index order on each frame tick, starting each one and forwarding
// its pixel stream to the single VGA write port until it finishes or times out.
module sprite_draw_scheduler #(
  parameter int unsigned N_SPRITES = 4,
  parameter logic [19:0] TIMEOUT   = 20'd50000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     frame_tick,
  input  logic [N_SPRITES-1:0]     sprite_mask,
  sprite_draw_scheduler_if.master  bus,
  output logic                     busy,
  output logic                     pass_done,
  output logic                     overrun,
  output logic [N_SPRITES-1:0]     timeout_flags
);

  localparam int unsigned    IdxW    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_SPRITES - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StStart, StWaitDone, StNext} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic [N_SPRITES-1:0] active_mask_q, active_mask_d;
  logic [19:0]          tmo_cnt_q, tmo_cnt_d;
  logic                 overrun_q, overrun_d;
  logic [N_SPRITES-1:0] tflags_q, tflags_d;
  logic                 pass_done_q, pass_done_d;

  logic                 vga_plot_q;
  logic [7:0]           vga_x_q;
  logic [6:0]           vga_y_q;
  logic [2:0]           vga_colour_q;

  int unsigned          sel;
  logic                 sel_plot;
  logic [7:0]           sel_x;
  logic [6:0]           sel_y;
  logic [2:0]           sel_colour;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    active_mask_d = active_mask_q;
    tmo_cnt_d     = tmo_cnt_q;
    overrun_d     = overrun_q;
    tflags_d      = tflags_q;
    pass_done_d   = 1'b0;
    bus.sprite_en = '0;

    // A tick during a pass queues at most one rerun; anything beyond that is an overrun.
    if (frame_tick && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (frame_tick || pending_q) begin
          active_mask_d = sprite_mask;
          idx_d         = '0;
          pending_d     = 1'b0;
          state_d       = StSelect;
        end
      end
      StSelect: begin
        state_d = active_mask_q[idx_q] ? StStart : StNext;
      end
      StStart: begin
        bus.sprite_en[idx_q] = 1'b1;
        tmo_cnt_d            = '0;
        state_d              = StWaitDone;
      end
      StWaitDone: begin
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 20'd1;
        if (bus.sprite_done[idx_q]) begin
          state_d = StNext;
        end else if (tmo_cnt_q == TIMEOUT - 20'd1) begin
          tflags_d[idx_q] = 1'b1;
          state_d         = StNext;
        end
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          pass_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StSelect;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel        = 32'(idx_q);
    sel_plot   = bus.sprite_plot[sel];
    sel_x      = bus.sprite_x[8*sel +: 8];
    sel_y      = bus.sprite_y[7*sel +: 7];
    sel_colour = bus.sprite_colour[3*sel +: 3];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      active_mask_q <= '0;
      tmo_cnt_q     <= '0;
      overrun_q     <= 1'b0;
      tflags_q      <= '0;
      pass_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      active_mask_q <= active_mask_d;
      tmo_cnt_q     <= tmo_cnt_d;
      overrun_q     <= overrun_d;
      tflags_q      <= tflags_d;
      pass_done_q   <= pass_done_d;
    end
  end

  // Coordinates only follow the owning sprite, so idle sprites never leak onto the VGA bus.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      vga_plot_q <= (state_q == StWaitDone) && sel_plot;
      if (state_q == StWaitDone) begin
        vga_x_q      <= sel_x;
        vga_y_q      <= sel_y;
        vga_colour_q <= sel_colour;
      end
    end
  end

  assign bus.vga_plot   = vga_plot_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;

  assign busy          = (state_q != StIdle);
  assign pass_done     = pass_done_q;
  assign overrun       = overrun_q;
  assign timeout_flags = tflags_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: four modelled sprites that finish 20 cycles after their start
// pulse, a pixel scoreboard, a table of whole-pass scenarios and a few hand-written sequences.
module tb_sprite_draw_scheduler;

  localparam int DoneLat = 20;
  localparam int Tmo     = 100;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [3:0] sprite_mask;
  logic       busy, pass_done, overrun;
  logic [3:0] timeout_flags;

  logic [3:0] hang;
  logic       noise1;
  int         scnt [4];

  int checks, errors, cyc;

  sprite_draw_scheduler_if #(.N_SPRITES(4)) bus ();

  sprite_draw_scheduler #(
    .N_SPRITES (4),
    .TIMEOUT   (20'd100)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .sprite_mask   (sprite_mask),
    .bus           (bus),
    .busy          (busy),
    .pass_done     (pass_done),
    .overrun       (overrun),
    .timeout_flags (timeout_flags)
  );

  always #5 clk = ~clk;

  // Sprite engines: counter runs 1..DoneLat after the start pulse, plotting every cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!resetn)                 scnt[i] <= 0;
      else if (bus.sprite_en[i])   scnt[i] <= 1;
      else if (scnt[i] == DoneLat) scnt[i] <= 0;
      else if (scnt[i] != 0)       scnt[i] <= scnt[i] + 1;
    end
  end

  always_comb begin
    bus.sprite_done   = '0;
    bus.sprite_plot   = '0;
    bus.sprite_x      = '0;
    bus.sprite_y      = '0;
    bus.sprite_colour = '0;
    for (int i = 0; i < 4; i++) begin
      if (scnt[i] != 0) begin
        bus.sprite_plot[i]          = 1'b1;
        bus.sprite_x[8*i +: 8]      = 8'(10*i + scnt[i]);
        bus.sprite_y[7*i +: 7]      = 7'(8*i + scnt[i]);
        bus.sprite_colour[3*i +: 3] = 3'(3*i + 3);
        bus.sprite_done[i]          = (scnt[i] == DoneLat) && !hang[i];
      end else if (i == 1 && noise1) begin
        bus.sprite_plot[i]     = 1'b1;
        bus.sprite_x[8*i +: 8] = 8'd99;
      end
    end
  end

  typedef struct {
    int         c;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } pix_t;

  pix_t q[$];
  int   en_cnt [4];
  int   first_en [4];
  int   pd_cnt, pd_last, cnt99, last_idx;
  logic [3:0] prev_en;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    pix_t e;
    if (!resetn) begin
      last_idx = -1;
      prev_en  = '0;
      return;
    end
    if (q.size() > 0 && q[0].c == cyc) begin
      e = q.pop_front();
      checks++;
      if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, e.x, e.y, e.col}) begin
        errors++;
        $display("FAIL pixel cycle %0d: got plot=%b x=%0d y=%0d c=%0d expected plot=1 x=%0d y=%0d c=%0d",
                 cyc, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, e.x, e.y, e.col);
      end
    end else begin
      checks++;
      if (bus.vga_plot !== 1'b0) begin
        errors++;
        $display("FAIL stray_vga_plot cycle %0d: got %b expected 0", cyc, bus.vga_plot);
      end
    end
    if (bus.vga_x == 8'd99) cnt99++;
    // Expected pixels come from the sprite model's own formula, one cycle later.
    for (int i = 0; i < 4; i++) begin
      if (scnt[i] >= 1 && scnt[i] <= DoneLat) begin
        e.c   = cyc + 1;
        e.x   = 8'(10*i + scnt[i]);
        e.y   = 7'(8*i + scnt[i]);
        e.col = 3'(3*i + 3);
        q.push_back(e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.sprite_en[i]) begin
        en_cnt[i]++;
        if (first_en[i] < 0) first_en[i] = cyc;
        checks++;
        if (prev_en[i] || i <= last_idx || $countones(bus.sprite_en) != 1) begin
          errors++;
          $display("FAIL en_pulse sprite %0d cycle %0d: got en=%b prev=%b last=%0d expected one-cycle in-order pulse",
                   i, cyc, bus.sprite_en, prev_en, last_idx);
        end
        last_idx = i;
      end
    end
    prev_en = bus.sprite_en;
    if (pass_done) begin
      pd_cnt++;
      pd_last  = cyc;
      last_idx = -1;
    end
  endtask

  task automatic step();
    monitor();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      en_cnt[i]   = 0;
      first_en[i] = -1;
    end
    pd_cnt  = 0;
    pd_last = -1;
    cnt99   = 0;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    frame_tick = 1'b0;
    step();
    step();
    resetn = 1'b1;
    clear_stats();
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [3:0] hang;
    logic       noise1;
    int         extra;
    int         passes;
    logic [3:0] exp_en;
    int         done_lat;
    logic [3:0] tflags;
    logic       ovr;
    int         gap23;
  } row_t;

  row_t rows [7];

  initial begin
    int t, n, e, base;
    string nm;

    // Done latency = 23 cycles per started sprite (SELECT, START, 20 WAIT, NEXT), 2 per skipped,
    // plus one for pass_done. A hung sprite waits Tmo cycles in WAIT instead of 20.
    rows[0] = '{4'b1111, 4'b0000, 1'b0, 0, 1, 4'b1111,  93, 4'b0000, 1'b0, 0};
    rows[1] = '{4'b0101, 4'b0000, 1'b1, 0, 1, 4'b0101,  51, 4'b0000, 1'b0, 0};
    rows[2] = '{4'b1111, 4'b0100, 1'b0, 0, 1, 4'b1111, 173, 4'b0100, 1'b0, Tmo + 3};
    rows[3] = '{4'b0000, 4'b0000, 1'b0, 0, 1, 4'b0000,   9, 4'b0000, 1'b0, 0};
    rows[4] = '{4'b1111, 4'b0000, 1'b0, 1, 2, 4'b1111, 186, 4'b0000, 1'b0, 0};
    rows[5] = '{4'b1111, 4'b0000, 1'b0, 2, 2, 4'b1111, 186, 4'b0000, 1'b1, 0};
    rows[6] = '{4'b1111, 4'b0000, 1'b0, 3, 2, 4'b1111, 186, 4'b0000, 1'b1, 0};

    checks = 0; errors = 0; cyc = 0;
    resetn = 1'b0; frame_tick = 1'b0; sprite_mask = '0; hang = '0; noise1 = 1'b0;
    prev_en = '0; last_idx = -1;
    clear_stats();

    repeat (3) step();
    resetn = 1'b1;
    repeat (10) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_pass_done", int'(pass_done), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_timeout_flags", int'(timeout_flags), 0);
    chk("reset_sprite_en", int'(bus.sprite_en), 0);
    chk("reset_vga", int'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);

    for (int r = 0; r < 7; r++) begin
      sprite_mask = rows[r].mask;
      hang        = rows[r].hang;
      noise1      = rows[r].noise1;
      do_reset();
      t = cyc;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk($sformatf("row%0d_busy_T+1", r), int'(busy), 1);
      n = 0;
      while (pd_cnt < rows[r].passes && n < 2000) begin
        frame_tick = 1'b0;
        for (int k = 0; k < rows[r].extra; k++)
          if (cyc == t + 10 + 10*k) frame_tick = 1'b1;
        step();
        n++;
      end
      frame_tick = 1'b0;
      if (pd_cnt < rows[r].passes) begin
        errors++;
        $display("FAIL row%0d_pass_timeout: got %0d passes expected %0d", r, pd_cnt, rows[r].passes);
      end
      repeat (30) step();
      chk($sformatf("row%0d_passes", r), pd_cnt, rows[r].passes);
      chk($sformatf("row%0d_done_lat", r), pd_last - t, rows[r].done_lat);
      for (int i = 0; i < 4; i++)
        chk($sformatf("row%0d_en_cnt%0d", r, i), en_cnt[i],
            rows[r].exp_en[i] ? rows[r].passes : 0);
      chk($sformatf("row%0d_tflags", r), int'(timeout_flags), int'(rows[r].tflags));
      chk($sformatf("row%0d_overrun", r), int'(overrun), int'(rows[r].ovr));
      chk($sformatf("row%0d_busy_end", r), int'(busy), 0);
      if (rows[r].noise1) chk($sformatf("row%0d_x99_seen", r), cnt99, 0);
      if (rows[r].passes == 1 && rows[r].exp_en[0])
        chk($sformatf("row%0d_en0_lat", r), first_en[0] - t, 2);
      if (rows[r].gap23 != 0)
        chk($sformatf("row%0d_gap23", r), first_en[3] - first_en[2], rows[r].gap23);
    end

    // Pixel latency: sprite 1 outputs x=30 y=28 colour=6 on its 20th drawing cycle.
    sprite_mask = 4'b0010; hang = '0; noise1 = 1'b0;
    do_reset();
    t = cyc;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    while (!bus.sprite_en[1] && n < 50) begin
      step();
      n++;
    end
    e = cyc;
    chk("pix_en1_lat", e - t, 4);
    repeat (DoneLat + 1) step();
    chk("pix_plot", int'(bus.vga_plot), 1);
    chk("pix_x", int'(bus.vga_x), 30);
    chk("pix_y", int'(bus.vga_y), 28);
    chk("pix_colour", int'(bus.vga_colour), 6);
    repeat (10) step();

    // Reset mid-pass: no start pulse may follow it.
    sprite_mask = 4'b1111;
    do_reset();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    while (en_cnt[1] == 0 && n < 200) begin
      step();
      n++;
    end
    chk("midrst_en1_seen", en_cnt[1], 1);
    repeat (5) step();
    resetn = 1'b0;
    step();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_en", int'(bus.sprite_en), 0);
    resetn = 1'b1;
    base = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
    repeat (60) step();
    chk("midrst_no_en", en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3], base);
    chk("midrst_no_pass_done", pd_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
